// File: rtl/hex_7seg_pkg.sv
// hex_7seg_pkg: active-high seven-segment patterns, bit order g,f,e,d,c,b,a
package hex_7seg_pkg;
   localparam logic [6:0] PAT_0 = 7'h3F;
   localparam logic [6:0] PAT_1 = 7'h06;
   localparam logic [6:0] PAT_2 = 7'h5B;
   localparam logic [6:0] PAT_3 = 7'h4F;
   localparam logic [6:0] PAT_4 = 7'h66;
   localparam logic [6:0] PAT_5 = 7'h6D;
   localparam logic [6:0] PAT_6 = 7'h7D;
   localparam logic [6:0] PAT_7 = 7'h07;
   localparam logic [6:0] PAT_8 = 7'h7F;
   localparam logic [6:0] PAT_9 = 7'h6F;
   localparam logic [6:0] PAT_A = 7'h77;
   localparam logic [6:0] PAT_B = 7'h7C;
   localparam logic [6:0] PAT_C = 7'h39;
   localparam logic [6:0] PAT_D = 7'h5E;
   localparam logic [6:0] PAT_E = 7'h79;
   localparam logic [6:0] PAT_F = 7'h71;
   localparam logic [6:0] SEG_ALL_ON  = 7'h7F;
   localparam logic [6:0] SEG_ALL_OFF = 7'h00;
endpackage

// File: rtl/hex_7seg_lut.sv
// hex_7seg_lut: combinational hex digit to active-high segment pattern
module hex_7seg_lut
   import hex_7seg_pkg::*;
(
   input  logic [3:0] x,
   output logic [6:0] pat
);
   always_comb begin
      pat = SEG_ALL_OFF;
      case (x)
         4'h0: pat = PAT_0;
         4'h1: pat = PAT_1;
         4'h2: pat = PAT_2;
         4'h3: pat = PAT_3;
         4'h4: pat = PAT_4;
         4'h5: pat = PAT_5;
         4'h6: pat = PAT_6;
         4'h7: pat = PAT_7;
         4'h8: pat = PAT_8;
         4'h9: pat = PAT_9;
         4'hA: pat = PAT_A;
         4'hB: pat = PAT_B;
         4'hC: pat = PAT_C;
         4'hD: pat = PAT_D;
         4'hE: pat = PAT_E;
         4'hF: pat = PAT_F;
         default: pat = SEG_ALL_OFF;
      endcase
   end
endmodule

// File: rtl/hex_7seg.sv
// hex_7seg: registered hex display driver with lamp-test/blank overrides and selectable polarity
module hex_7seg
   import hex_7seg_pkg::*;
#(
   parameter bit ACTIVE_LOW = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] X,
   input  logic       en,
   input  logic       blank,
   input  logic       lamp_test,
   output logic [6:0] SEG
);
   localparam logic [6:0] MASK = ACTIVE_LOW ? 7'h7F : 7'h00;
   logic [6:0] pat, nxt;
   hex_7seg_lut u_lut (.x(X), .pat(pat));
   always_comb nxt = lamp_test ? SEG_ALL_ON : blank ? SEG_ALL_OFF : pat;
   // Overrides load even with en=0 so their pattern persists after release
   always_ff @(posedge clk)
      if (rst) SEG <= SEG_ALL_OFF ^ MASK;
      else if (lamp_test || blank || en) SEG <= nxt ^ MASK;
endmodule

// File: tb/tb_hex_7seg.sv
// tb_hex_7seg: vector table plus randomized run against a digit-table model, both polarities
module tb_hex_7seg;
   logic clk = 0, rst = 0, en = 0, blank = 0, lamp_test = 0;
   logic [3:0] X = 0;
   logic [6:0] seg_al, seg_ah;
   int n_cmp = 0, n_bad = 0;

   hex_7seg #(.ACTIVE_LOW(1)) dut_al (.clk(clk), .rst(rst), .X(X), .en(en), .blank(blank),
                                      .lamp_test(lamp_test), .SEG(seg_al));
   hex_7seg #(.ACTIVE_LOW(0)) dut_ah (.clk(clk), .rst(rst), .X(X), .en(en), .blank(blank),
                                      .lamp_test(lamp_test), .SEG(seg_ah));

   always #5 clk = ~clk;

   logic [6:0] hi [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
   logic [6:0] lit;

   typedef struct {
      logic r;
      logic [3:0] x;
      logic e, b, l;
      logic [6:0] exp;
   } vec_t;
   vec_t tv[$];

   task automatic step(input logic r, input logic [3:0] x, input logic e, b, l);
      rst = r; X = x; en = e; blank = b; lamp_test = l;
      @(posedge clk);
      #1;
      lit = r ? 7'h00 : l ? 7'h7F : b ? 7'h00 : e ? hi[x] : lit;
   endtask

   task automatic check(input string name, input logic [6:0] act, exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   initial begin
      logic [6:0] al_seq [17] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00,
                                  7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E, 7'h40};
      tv.push_back('{1, 0, 0, 0, 0, 7'h7F});
      tv.push_back('{1, 0, 0, 0, 0, 7'h7F});
      tv.push_back('{0, 3, 0, 0, 0, 7'h7F});
      for (int i = 0; i < 17; i++) tv.push_back('{0, 4'(i), 1, 0, 0, al_seq[i]});
      tv.push_back('{0, 8, 1, 0, 0, 7'h00});
      tv.push_back('{0, 1, 0, 0, 0, 7'h00});
      tv.push_back('{0, 1, 1, 1, 1, 7'h00});
      tv.push_back('{0, 1, 1, 1, 0, 7'h7F});
      tv.push_back('{0, 2, 0, 0, 0, 7'h7F});
      tv.push_back('{0, 2, 0, 0, 1, 7'h00});
      tv.push_back('{0, 6, 0, 0, 0, 7'h00});
      tv.push_back('{0, 4, 1, 0, 0, 7'h19});
      tv.push_back('{1, 5, 1, 0, 0, 7'h7F});
      tv.push_back('{0, 5, 1, 0, 0, 7'h12});
      tv.push_back('{0, 5, 0, 0, 0, 7'h12});
      lit = 7'h00;
      foreach (tv[i]) begin
         step(tv[i].r, tv[i].x, tv[i].e, tv[i].b, tv[i].l);
         check($sformatf("vec%0d_al", i), seg_al, tv[i].exp);
         check($sformatf("vec%0d_ah", i), seg_ah, ~tv[i].exp);
      end
      step(0, 4'hA, 1, 0, 0);
      check("ah_digit_A", seg_ah, 7'h77);
      step(1, 4'hA, 1, 0, 0);
      check("ah_reset", seg_ah, 7'h00);
      check("al_reset", seg_al, 7'h7F);
      step(0, 4'hA, 0, 0, 0);
      check("ah_hold_after_reset", seg_ah, 7'h00);
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(15) == 0, 4'($urandom), $urandom_range(1), $urandom_range(7) == 0,
              $urandom_range(7) == 0);
         check($sformatf("rnd%0d_al", i), seg_al, ~lit);
         check($sformatf("rnd%0d_ah", i), seg_ah, lit);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/hex_7seg.md
HEX_7SEG -- requirements
Module: hex_7seg

Interface
REQ-001 The block SHALL provide parameter ACTIVE_LOW, default 1, where 1 means segment on = 0 (common anode) and 0 means segment on = 1.
REQ-002 The block SHALL provide port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 The block SHALL provide port rst, input, 1 bit: reset, synchronous, active-high.
REQ-004 The block SHALL provide port X, input, 4 bits: hex digit to display, 0x0..0xF.
REQ-005 The block SHALL provide port en, input, 1 bit: 1 = capture a new decode of X; 0 = hold SEG.
REQ-006 The block SHALL provide port blank, input, 1 bit: 1 = all segments off.
REQ-007 The block SHALL provide port lamp_test, input, 1 bit: 1 = all segments on.
REQ-008 The block SHALL provide port SEG, output, 7 bits, registered; bit order SEG[6:0] = g,f,e,d,c,b,a.

Function
REQ-009 The block SHALL register SEG with exactly 1-cycle latency: the value from the inputs sampled at edge N appears after edge N and holds until the next update.
REQ-010 The block SHALL decode X to the active-high segment patterns 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07, 8:7F, 9:6F, A:77, b:7C, C:39, d:5E, E:79, F:71.
REQ-011 With ACTIVE_LOW=1, SEG SHALL be the bitwise inverse of the REQ-010 pattern (e.g. 0→40, 8→00, F→0E).
REQ-012 The block SHALL update SEG on each edge with priority rst > lamp_test > blank > en > hold.
REQ-013 When lamp_test=1, SEG SHALL show all segments on (7F active-high, 00 active-low), regardless of en and blank.
REQ-014 When blank=1 and lamp_test=0, SEG SHALL show all segments off (00 active-high, 7F active-low), regardless of en.
REQ-015 When en=0 and neither override is active, SEG SHALL hold its previous value while X changes.
REQ-016 When lamp_test or blank deasserts with en=0, SEG SHALL keep the override pattern until the next en=1 edge.
REQ-017 X wrap-around F→0 SHALL need no special handling; each value decodes independently.
REQ-018 X containing X or Z bits is outside the contract; the decoder default branch SHALL output the all-off pattern.
REQ-019 SEG SHALL never glitch between edges, since it is driven only from the flop.

Reset
REQ-020 When rst=1 at a rising edge, SEG SHALL load the all-off pattern (7F when ACTIVE_LOW=1), overriding all other inputs.
REQ-021 The block SHALL have no asynchronous reset path; before the first reset edge SEG is undefined.
REQ-022 Reset asserted mid-stream SHALL take effect at that edge, and the first decode after deassertion SHALL occur on the next edge with en=1.

Structure
REQ-023 A shared package hex_7seg_pkg SHALL hold the 16 active-high pattern constants plus SEG_ALL_ON (7F) and SEG_ALL_OFF (00).
REQ-024 One combinational sub-module hex_7seg_lut SHALL map the 4-bit input to the 7-bit active-high pattern.
REQ-025 The hex_7seg top SHALL contain the polarity inversion, the override priority mux and the output register.

Verification
REQ-026 Verification SHALL check: rst=1 for 2 cycles, then en=0 → SEG=7F (ACTIVE_LOW=1).
REQ-027 Verification SHALL check: en=1, X stepping 0..F then wrapping to 0, one value per cycle → SEG one cycle later = 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E, then 40.
REQ-028 Verification SHALL check: X=8, en=1 (SEG=00), then en=0 with X=1 → SEG stays 00.
REQ-029 Verification SHALL check: blank=1 and lamp_test=1 together → SEG=00 (lamp test wins); drop lamp_test only → SEG=7F.
REQ-030 Verification SHALL check: rst=1 pulsed while en=1, X=5 → SEG=7F at that edge, then 12 on the following edge.
REQ-031 Verification SHALL check: ACTIVE_LOW=0, X=A, en=1 → SEG=77; reset → SEG=00.
